// File: rtl/dwt_pkg.sv
// Shared DWT datapath definitions: widths, reconstruction FSM states and
// the 10-bit signed to 8-bit unsigned saturating clamp.
package dwt_pkg;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 8;
  localparam int WIDE_W = COEF_W + 2;

  typedef enum logic [1:0] {IDLE, SEND_P1, SEND_P2} state_e;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             sat;
  } sat_t;

  function automatic sat_t sat8(input logic signed [WIDE_W-1:0] v);
    sat_t r;
    if (v < 0) begin
      r.pix = '0;
      r.sat = 1'b1;
    end else if (v > $signed(WIDE_W'(255))) begin
      r.pix = '1;
      r.sat = 1'b1;
    end else begin
      r.pix = v[PIX_W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction
endpackage

// File: rtl/haar_butterfly.sv
// Combinational inverse Haar butterfly: p1 = a + d, p2 = a - d, both clamped
// to 8 bits with a per-pixel saturation flag.
module haar_butterfly
  import dwt_pkg::*;
(
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] d,
  output logic [PIX_W-1:0]  p1,
  output logic [PIX_W-1:0]  p2,
  output logic              sat1,
  output logic              sat2
);
  logic signed [WIDE_W-1:0] a_x, d_x, sum, dif;
  sat_t r1, r2;

  // a is unsigned, d is two's complement; widen both before combining
  assign a_x = $signed({2'b00, a});
  assign d_x = $signed({{2{d[COEF_W-1]}}, d});
  assign sum = a_x + d_x;
  assign dif = a_x - d_x;

  assign r1   = sat8(sum);
  assign r2   = sat8(dif);
  assign p1   = r1.pix;
  assign p2   = r2.pix;
  assign sat1 = r1.sat;
  assign sat2 = r2.sat;
endmodule

// File: rtl/haar_inv_recon.sv
// Inverse 1-D Haar reconstruction: one coefficient pair in, two saturated
// pixels out, with an end-of-line marker every LINE_PAIRS pairs.
module haar_inv_recon
  import dwt_pkg::*;
#(
  parameter int LINE_PAIRS = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_a,
  input  logic [COEF_W-1:0] coef_d,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_eol,
  output logic              pix_sat
);
  localparam int CNT_W = $clog2(LINE_PAIRS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_PAIRS - 1);

  state_e           state_q, state_d;
  logic [PIX_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic             s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;

  logic [PIX_W-1:0] bf_p1, bf_p2;
  logic             bf_s1, bf_s2;
  logic             pix_hs, coef_hs;

  haar_butterfly u_bf (
    .a    (coef_a),
    .d    (coef_d),
    .p1   (bf_p1),
    .p2   (bf_p2),
    .sat1 (bf_s1),
    .sat2 (bf_s2)
  );

  // The SEND_P2 term lets a new pair land on the same edge p2 leaves,
  // which is what removes the bubble between pairs.
  assign coef_ready = rst_n && ((state_q == IDLE) ||
                                (state_q == SEND_P2 && pix_ready));
  assign coef_hs    = coef_valid && coef_ready;
  assign pix_hs     = pix_valid && pix_ready;

  always_comb begin
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_sat   = 1'b0;
    pix_eol   = 1'b0;
    case (state_q)
      SEND_P1: begin
        pix_valid = 1'b1;
        pix_data  = p1_q;
        pix_sat   = s1_q;
      end
      SEND_P2: begin
        pix_valid = 1'b1;
        pix_data  = p2_q;
        pix_sat   = s2_q;
        pix_eol   = (pair_cnt_q == CNT_LAST);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pair_cnt_d = pair_cnt_q;
    p1_d       = coef_hs ? bf_p1 : p1_q;
    p2_d       = coef_hs ? bf_p2 : p2_q;
    s1_d       = coef_hs ? bf_s1 : s1_q;
    s2_d       = coef_hs ? bf_s2 : s2_q;
    case (state_q)
      IDLE:    if (coef_hs) state_d = SEND_P1;
      SEND_P1: if (pix_hs) state_d = SEND_P2;
      SEND_P2: if (pix_hs) begin
        pair_cnt_d = (pair_cnt_q == CNT_LAST) ? '0 : pair_cnt_q + 1'b1;
        state_d    = coef_hs ? SEND_P1 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      p1_q       <= '0;
      p2_q       <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      pair_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end
endmodule

// File: tb/tb_haar_inv_recon.sv
// Directed bench for haar_inv_recon with LINE_PAIRS=4: vector table of
// single pairs plus backpressure, streaming, overlap and reset sequences.
module tb_haar_inv_recon;
  localparam int LP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coef_valid = 1'b0;
  logic       coef_ready;
  logic [7:0] coef_a = '0;
  logic [7:0] coef_d = '0;
  logic       pix_valid;
  logic       pix_ready = 1'b0;
  logic [7:0] pix_data;
  logic       pix_eol;
  logic       pix_sat;

  haar_inv_recon #(.LINE_PAIRS(LP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_a     (coef_a),
    .coef_d     (coef_d),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_eol    (pix_eol),
    .pix_sat    (pix_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         p1;
    bit         s1;
    int         p2;
    bit         s2;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_m = 0;

  logic       r_valid, r_ready, r_eol, r_sat;
  logic [7:0] r_data;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: drive, sample mid-low-phase, pass the posedge,
  // return at the following negedge.
  task automatic step(input logic cv, input logic [7:0] a, input logic [7:0] d,
                      input logic pr);
    coef_valid = cv;
    coef_a     = a;
    coef_d     = d;
    pix_ready  = pr;
    #1;
    r_valid = pix_valid;
    r_ready = coef_ready;
    r_data  = pix_data;
    r_eol   = pix_eol;
    r_sat   = pix_sat;
    @(negedge clk);
  endtask

  function automatic bit eol_and_advance();
    bit e = (cnt_m == LP - 1);
    cnt_m = (cnt_m + 1) % LP;
    return e;
  endfunction

  // One isolated pair from IDLE with pix_ready high.
  task automatic run_pair(input vec_t v, input string tag);
    step(1'b1, v.a, v.d, 1'b1);
    chk({tag, " idle ready"}, int'(r_ready), 1);
    chk({tag, " idle valid"}, int'(r_valid), 0);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    chk({tag, " p1 valid"}, int'(r_valid), 1);
    chk({tag, " p1 data"}, int'(r_data), v.p1);
    chk({tag, " p1 sat"}, int'(r_sat), int'(v.s1));
    chk({tag, " p1 eol"}, int'(r_eol), 0);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    chk({tag, " p2 data"}, int'(r_data), v.p2);
    chk({tag, " p2 sat"}, int'(r_sat), int'(v.s2));
    chk({tag, " p2 eol"}, int'(r_eol), int'(eol_and_advance()));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    coef_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_m = 0;
    @(negedge clk);
  endtask

  vec_t vecs[8];
  vec_t v;
  int   exp_pix[$];
  int   exp_eol[$];
  int   idx, pix_n;
  bit   saw_idle;

  initial begin
    vecs[0] = '{8'd150, 8'd50,  200, 1'b0, 100, 1'b0};
    vecs[1] = '{8'd250, 8'd20,  255, 1'b1, 230, 1'b0};
    vecs[2] = '{8'd10,  8'hEC,  0,   1'b1, 30,  1'b0};
    vecs[3] = '{8'd100, 8'h80,  0,   1'b1, 228, 1'b0};
    vecs[4] = '{8'd200, 8'd127, 255, 1'b1, 73,  1'b0};
    vecs[5] = '{8'd0,   8'd0,   0,   1'b0, 0,   1'b0};
    vecs[6] = '{8'd255, 8'hFF,  254, 1'b0, 255, 1'b1};
    vecs[7] = '{8'd128, 8'd127, 255, 1'b0, 1,   1'b0};

    // Reset state
    @(negedge clk);
    #1;
    chk("rst coef_ready", int'(coef_ready), 0);
    chk("rst pix_valid", int'(pix_valid), 0);
    chk("rst pix_data", int'(pix_data), 0);
    chk("rst pix_eol", int'(pix_eol), 0);
    chk("rst pix_sat", int'(pix_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: two full rows, eol on the 4th and 8th pair
    for (int i = 0; i < 8; i++) run_pair(vecs[i], $sformatf("vec%0d", i));
    step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("table back to idle", int'(r_valid), 0);

    // Backpressure: 3 stall cycles on each pixel
    step(1'b1, 8'd150, 8'd50, 1'b0);
    chk("bp accept", int'(r_ready), 1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'd1, 8'd1, 1'b0);
      chk("bp p1 held", int'(r_data), 200);
      chk("bp p1 valid", int'(r_valid), 1);
      chk("bp p1 no ready", int'(r_ready), 0);
    end
    step(1'b1, 8'd1, 8'd1, 1'b1);
    chk("bp p1 hs data", int'(r_data), 200);
    chk("bp p1 hs no ready", int'(r_ready), 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'd0, 8'd0, 1'b0);
      chk("bp p2 held", int'(r_data), 100);
      chk("bp p2 valid", int'(r_valid), 1);
    end
    step(1'b0, 8'd0, 8'd0, 1'b1);
    chk("bp p2 hs data", int'(r_data), 100);
    chk("bp p2 eol", int'(r_eol), int'(eol_and_advance()));
    step(1'b0, 8'd0, 8'd0, 1'b1);
    chk("bp idle", int'(r_valid), 0);

    // Simultaneous: coef_valid rises during the SEND_P2 handshake
    step(1'b1, 8'd150, 8'd50, 1'b1);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    chk("sim p1", int'(r_data), 200);
    step(1'b1, 8'd250, 8'd20, 1'b1);
    chk("sim p2", int'(r_data), 100);
    chk("sim ready in p2", int'(r_ready), 1);
    void'(eol_and_advance());
    step(1'b0, 8'd0, 8'd0, 1'b1);
    chk("sim new p1 valid", int'(r_valid), 1);
    chk("sim new p1", int'(r_data), 255);
    chk("sim new p1 sat", int'(r_sat), 1);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    chk("sim new p2", int'(r_data), 230);
    void'(eol_and_advance());

    // Streaming: 8 back-to-back pairs from a fresh row
    do_reset();
    exp_pix.delete();
    exp_eol.delete();
    for (int i = 0; i < 8; i++) begin
      exp_pix.push_back(i * 20 + 10 + i);
      exp_pix.push_back(i * 20 + 10 - i);
      exp_eol.push_back(0);
      exp_eol.push_back((i % LP) == LP - 1 ? 1 : 0);
    end
    idx = 0;
    pix_n = 0;
    saw_idle = 1'b0;
    for (int c = 0; c < 24 && !saw_idle; c++) begin
      step(idx < 8, 8'(idx * 20 + 10), 8'(idx), 1'b1);
      if (r_valid) begin
        if (pix_n < 16) begin
          chk($sformatf("stream px%0d", pix_n + 1), int'(r_data), exp_pix[pix_n]);
          chk($sformatf("stream eol%0d", pix_n + 1), int'(r_eol), exp_eol[pix_n]);
        end
        pix_n++;
      end else if (c > 0) begin
        saw_idle = 1'b1;
      end
      if (idx < 8 && r_ready) idx++;
    end
    chk("stream pixel count", pix_n, 16);
    chk("stream ended idle", int'(saw_idle), 1);

    // Reset mid-pair: async assert during SEND_P1 of pair 2
    do_reset();
    v = '{8'd150, 8'd50, 200, 1'b0, 100, 1'b0};
    run_pair(v, "rr pair1");
    coef_valid = 1'b1;
    coef_a = 8'd250;
    coef_d = 8'd20;
    pix_ready = 1'b0;
    @(negedge clk);
    coef_valid = 1'b0;
    #1;
    chk("rr in p1", int'(pix_data), 255);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr async valid", int'(pix_valid), 0);
    chk("rr async data", int'(pix_data), 0);
    chk("rr async sat", int'(pix_sat), 0);
    chk("rr async eol", int'(pix_eol), 0);
    chk("rr async ready", int'(coef_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_m = 0;
    @(negedge clk);
    for (int i = 0; i < LP; i++) run_pair(v, $sformatf("rr row%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
